multi_hash_ram_bank: RTL



---
 rtl/multi_hash_ram_pkg.sv | 13 +
 rtl/dual_port_ram.sv | 17 +
 rtl/multi_hash_ram_clr_fsm.sv | 33 +++
 rtl/multi_hash_ram_bank.sv | 67 ++++++
 4 files changed

// File: rtl/multi_hash_ram_pkg.sv
// multi_hash_ram_pkg: shared FSM encoding, entry width and slice offsets for multi_hash_ram_bank
package multi_hash_ram_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_CLR = 1'b1} state_t;
  function automatic int entry_w(int tw, int rw, int dw);
    return tw + rw + dw + 1;
  endfunction
  function automatic int row_off(int t, int sn, int ew);
    return t * sn * ew;
  endfunction
  function automatic int slot_off(int t, int s, int sn, int ew);
    return (t * sn + s) * ew;
  endfunction
endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: asynchronous-read port A, synchronous-write port B, no reset
module dual_port_ram #(
  parameter int DPW = 6,
  parameter int DW  = 8
) (
  input  logic           clk,
  input  logic [DPW-1:0] a_addr,
  output logic [DW-1:0]  a_dout,
  input  logic           b_we,
  input  logic [DPW-1:0] b_addr,
  input  logic [DW-1:0]  b_din
);
  logic [DW-1:0] mem [2**DPW];
  always_ff @(posedge clk)
    if (b_we) mem[b_addr] <= b_din;
  assign a_dout = mem[a_addr];
endmodule

// File: rtl/multi_hash_ram_clr_fsm.sv
// multi_hash_ram_clr_fsm: clear sweep sequencer; every reset starts a full sweep
module multi_hash_ram_clr_fsm import multi_hash_ram_pkg::*; #(
  parameter int HW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req_i,
  output state_t        state,
  output logic [HW-1:0] clr_addr,
  output logic          busy_o,
  output logic          clr_done_o
);
  assign busy_o = state == ST_CLR;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_CLR;
      clr_addr   <= '0;
      clr_done_o <= 1'b0;
    end else begin
      clr_done_o <= 1'b0;
      if (state == ST_CLR) begin
        clr_addr <= clr_addr + 1'b1;
        if (&clr_addr) begin
          state      <= ST_IDLE;
          clr_done_o <= 1'b1;
        end
      end else if (clr_req_i) begin
        state    <= ST_CLR;
        clr_addr <= '0;
      end
    end
  end
endmodule

// File: rtl/multi_hash_ram_bank.sv
// multi_hash_ram_bank: NT parallel hash tables of SN-slot rows with lookup, per-table write and clear sweep
// Optional macro MHR_WR_BYPASS_EN forwards same-cycle write data to a colliding lookup.
module multi_hash_ram_bank import multi_hash_ram_pkg::*; #(
  parameter int  NT = 2,
  parameter int  SN = 4,
  parameter int  HW = 6,
  parameter int  DW = 19,
  parameter int  RW = 20,
  parameter int  TW = 0,
  localparam int EW = entry_w(TW, RW, DW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lk_vld_i,
  output logic               lk_rdy_o,
  input  logic [NT*HW-1:0]   lk_addr_i,
  output logic               lk_vld_o,
  output logic [NT*SN*EW-1:0] lk_data_o,
  input  logic [NT-1:0]      wr_en_i,
  input  logic [NT*HW-1:0]   wr_addr_i,
  input  logic [NT*SN*EW-1:0] wr_data_i,
  output logic               wr_rdy_o,
  input  logic               clr_req_i,
  output logic               busy_o,
  output logic               clr_done_o
);
  state_t                state;
  logic [HW-1:0]         clr_addr;
  logic [NT*SN*EW-1:0]   rd, nxt;
  logic                  idle, acc;
  assign idle     = state == ST_IDLE;
  assign lk_rdy_o = idle;
  assign wr_rdy_o = idle;
  assign acc      = lk_vld_i & idle;
  multi_hash_ram_clr_fsm #(.HW(HW)) u_fsm (
    .clk, .rst_n, .clr_req_i, .state, .clr_addr, .busy_o, .clr_done_o
  );
  for (genvar t = 0; t < NT; t++) begin : g_t
    localparam int R = row_off(t, SN, EW);
`ifdef MHR_WR_BYPASS_EN
    assign nxt[R +: SN*EW] = (wr_en_i[t] && wr_addr_i[t*HW +: HW] == lk_addr_i[t*HW +: HW]) ?
                             wr_data_i[R +: SN*EW] : rd[R +: SN*EW];
`else
    assign nxt[R +: SN*EW] = rd[R +: SN*EW];
`endif
    for (genvar s = 0; s < SN; s++) begin : g_s
      localparam int O = slot_off(t, s, SN, EW);
      dual_port_ram #(.DPW(HW), .DW(EW)) u_ram (
        .clk,
        .a_addr (lk_addr_i[t*HW +: HW]),
        .a_dout (rd[O +: EW]),
        .b_we   (busy_o | (idle & wr_en_i[t])),
        .b_addr (busy_o ? clr_addr : wr_addr_i[t*HW +: HW]),
        .b_din  (busy_o ? '0 : wr_data_i[O +: EW])
      );
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_vld_o  <= 1'b0;
      lk_data_o <= '0;
    end else begin
      lk_vld_o  <= acc;
      lk_data_o <= acc ? nxt : lk_data_o;
    end
  end
endmodule
